// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for a single-ported unified memory, data-first with fetch anti-starvation.
// Define MEM_TIMEOUT_EN to add the ACK watchdog and the sticky ERR output.
module mem_port_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT  = 16
`endif
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              I_REQ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic              I_GNT,
   output logic              I_VALID,
   output logic [DATA_W-1:0] I_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [1:0]        D_BYTE_SEL,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   output logic              D_GNT,
   output logic              D_VALID,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              M_REQ,
   output logic              M_WE,
   output logic [1:0]        M_BYTE_SEL,
   output logic [ADDR_W-1:0] M_ADDR,
   output logic [DATA_W-1:0] M_WDATA,
   input  logic              M_ACK,
   input  logic [DATA_W-1:0] M_RDATA,
   output logic              STALL_F,
   output logic              STALL_M
`ifdef MEM_TIMEOUT_EN
   , output logic            ERR
`endif
);
   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
   localparam int SW = $clog2(STARVE_MAX + 1);
   state_t state, state_nxt;
   logic [SW-1:0] starve_cnt;
   logic slot, starved, pick_i, done, tmo;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      slot      = (state == IDLE) | M_ACK;
      starved   = starve_cnt == SW'(STARVE_MAX);
      pick_i    = I_REQ & (~D_REQ | starved);
      I_GNT     = slot & pick_i;
      D_GNT     = slot & D_REQ & ~pick_i;
      done      = (state != IDLE) & (M_ACK | tmo);
      state_nxt = I_GNT ? I_BUSY : D_GNT ? D_BUSY : (slot | tmo) ? IDLE : state;
   end
   assign M_REQ   = state != IDLE;
   assign STALL_F = (I_REQ & ~I_GNT) | (state == I_BUSY);
   assign STALL_M = (D_REQ & ~D_GNT) | (state == D_BUSY);
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         I_VALID    <= 1'b0;
         D_VALID    <= 1'b0;
         I_RDATA    <= '0;
         D_RDATA    <= '0;
         M_WE       <= 1'b0;
         M_BYTE_SEL <= '0;
         M_ADDR     <= '0;
         M_WDATA    <= '0;
         starve_cnt <= '0;
      end else begin
         I_VALID <= done & (state == I_BUSY);
         D_VALID <= done & (state == D_BUSY);
         if (done & (state == I_BUSY)) I_RDATA <= M_ACK ? M_RDATA : DATA_W'(32'h0000_0013);
         if (done & (state == D_BUSY) & ~M_WE) D_RDATA <= M_ACK ? M_RDATA : '0;
         if (I_GNT | D_GNT) begin
            M_WE       <= D_GNT & D_WE;
            M_BYTE_SEL <= D_GNT ? D_BYTE_SEL : 2'b10;
            M_ADDR     <= D_GNT ? D_ADDR : I_ADDR;
            M_WDATA    <= D_GNT ? D_WDATA : '0;
         end
         starve_cnt <= I_GNT ? '0 : (D_GNT & I_REQ & ~starved) ? starve_cnt + 1'b1 : starve_cnt;
      end
`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
   // Fires on the TIMEOUT-th consecutive un-acked BUSY cycle.
   assign tmo = (state != IDLE) & ~M_ACK & (tmo_cnt == TW'(TIMEOUT - 1));
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         tmo_cnt <= '0;
         ERR     <= 1'b0;
      end else begin
         tmo_cnt <= ((state != IDLE) & ~M_ACK & ~tmo) ? tmo_cnt + 1'b1 : '0;
         ERR     <= ERR | tmo;
      end
`else
   assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed-vector bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   logic        CLK = 1'b0, RST_N = 1'b0;
   logic        I_REQ = 0, I_GNT, I_VALID;
   logic [13:0] I_ADDR = '0;
   logic [31:0] I_RDATA;
   logic        D_REQ = 0, D_WE = 0, D_GNT, D_VALID;
   logic [1:0]  D_BYTE_SEL = '0;
   logic [13:0] D_ADDR = '0;
   logic [31:0] D_WDATA = '0, D_RDATA;
   logic        M_REQ, M_WE, M_ACK = 0;
   logic [1:0]  M_BYTE_SEL;
   logic [13:0] M_ADDR;
   logic [31:0] M_WDATA, M_RDATA = '0;
   logic        STALL_F, STALL_M;
`ifdef MEM_TIMEOUT_EN
   logic        ERR;
`endif
   int checks = 0, failures = 0;
   logic [31:0] d_prev;
   always #5 CLK = ~CLK;
   mem_port_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_BYTE_SEL(D_BYTE_SEL), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
      .M_REQ(M_REQ), .M_WE(M_WE), .M_BYTE_SEL(M_BYTE_SEL), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
      .M_ACK(M_ACK), .M_RDATA(M_RDATA), .STALL_F(STALL_F), .STALL_M(STALL_M)
`ifdef MEM_TIMEOUT_EN
      , .ERR(ERR)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      tick();
      tick();
      chk("rst_mreq", 32'(M_REQ), 0);
      chk("rst_ivalid", 32'(I_VALID), 0);
      chk("rst_dvalid", 32'(D_VALID), 0);
      chk("rst_maddr", 32'(M_ADDR), 0);
      chk("rst_drdata", D_RDATA, 0);
`ifdef MEM_TIMEOUT_EN
      chk("rst_err", 32'(ERR), 0);
`endif
      RST_N = 1'b1;
      tick();
      // fetch only
      I_REQ = 1; I_ADDR = 14'h0010; #1;
      chk("t1_igant", 32'(I_GNT), 1);
      chk("t1_stallf_gnt", 32'(STALL_F), 0);
      tick();
      I_REQ = 0; M_ACK = 1; M_RDATA = 32'h0050_0093; #1;
      chk("t1_mreq", 32'(M_REQ), 1);
      chk("t1_maddr", 32'(M_ADDR), 32'h10);
      chk("t1_mwe", 32'(M_WE), 0);
      chk("t1_stallf_busy", 32'(STALL_F), 1);
      tick();
      M_ACK = 0; #1;
      chk("t1_ivalid", 32'(I_VALID), 1);
      chk("t1_irdata", I_RDATA, 32'h0050_0093);
      chk("t1_mreq_idle", 32'(M_REQ), 0);
      tick();
      chk("t1_ivalid_pulse", 32'(I_VALID), 0);
      // simultaneous requests: data first
      I_REQ = 1; I_ADDR = 14'h0020; D_REQ = 1; D_WE = 0; D_ADDR = 14'h0100; #1;
      chk("t2_dgnt", 32'(D_GNT), 1);
      chk("t2_ignt", 32'(I_GNT), 0);
      chk("t2_stallf", 32'(STALL_F), 1);
      tick();
      D_REQ = 0; M_ACK = 1; M_RDATA = 32'hCAFE_0001; #1;
      chk("t2_maddr_d", 32'(M_ADDR), 32'h100);
      chk("t2_stallm", 32'(STALL_M), 1);
      chk("t2_ignt_ack", 32'(I_GNT), 1);
      tick();
      I_REQ = 0; M_RDATA = 32'h1111_1111; #1;
      chk("t2_dvalid", 32'(D_VALID), 1);
      chk("t2_drdata", D_RDATA, 32'hCAFE_0001);
      chk("t2_ivalid_early", 32'(I_VALID), 0);
      chk("t2_maddr_i", 32'(M_ADDR), 32'h20);
      chk("t2_stallf_busy", 32'(STALL_F), 1);
      tick();
      M_ACK = 0; #1;
      chk("t2_ivalid", 32'(I_VALID), 1);
      chk("t2_irdata", I_RDATA, 32'h1111_1111);
      tick();
      // starvation: four data grants, then fetch
      I_REQ = 1; D_REQ = 1; I_ADDR = 14'h0030; D_ADDR = 14'h0200;
      for (int k = 0; k < 5; k++) begin
         M_ACK = k > 0; M_RDATA = 32'(k); #1;
         chk($sformatf("t3_dgnt%0d", k), 32'(D_GNT), 32'(k < 4));
         chk($sformatf("t3_ignt%0d", k), 32'(I_GNT), 32'(k == 4));
         tick();
      end
      I_REQ = 0; D_REQ = 0; M_ACK = 1; M_RDATA = 32'h2222_2222; #1;
      chk("t3_starve_clr", 32'(dut.starve_cnt), 0);
      chk("t3_dvalid", 32'(D_VALID), 1);
      chk("t3_drdata", D_RDATA, 32'd4);
      d_prev = 32'd4;
      tick();
      M_ACK = 0; #1;
      chk("t3_ivalid", 32'(I_VALID), 1);
      chk("t3_irdata", I_RDATA, 32'h2222_2222);
      tick();
      // store
      D_REQ = 1; D_WE = 1; D_BYTE_SEL = 2'b10; D_ADDR = 14'h0040; D_WDATA = 32'hDEAD_BEEF; #1;
      chk("t4_dgnt", 32'(D_GNT), 1);
      tick();
      D_REQ = 0; D_WE = 0; M_ACK = 1; M_RDATA = 32'h1234_5678; #1;
      chk("t4_mwe", 32'(M_WE), 1);
      chk("t4_mwdata", M_WDATA, 32'hDEAD_BEEF);
      chk("t4_mbsel", 32'(M_BYTE_SEL), 2);
      chk("t4_maddr", 32'(M_ADDR), 32'h40);
      tick();
      M_ACK = 0; #1;
      chk("t4_dvalid", 32'(D_VALID), 1);
      chk("t4_drdata_hold", D_RDATA, d_prev);
      tick();
      // async reset mid-transaction
      D_REQ = 1; D_ADDR = 14'h0050; #1;
      chk("t5_dgnt", 32'(D_GNT), 1);
      tick();
      D_REQ = 0; #1;
      chk("t5_mreq", 32'(M_REQ), 1);
      RST_N = 0; #1;
      chk("t5_mreq_async", 32'(M_REQ), 0);
      M_ACK = 1;
      tick();
      RST_N = 1;
      tick();
      M_ACK = 0; #1;
      chk("t5_dvalid0", 32'(D_VALID), 0);
      chk("t5_mreq_idle", 32'(M_REQ), 0);
      tick();
      chk("t5_dvalid1", 32'(D_VALID), 0);
      chk("t5_drdata", D_RDATA, 0);
`ifdef MEM_TIMEOUT_EN
      begin
         int n = 0;
         I_REQ = 1; I_ADDR = 14'h0060; #1;
         chk("t6_ignt", 32'(I_GNT), 1);
         tick();
         I_REQ = 0;
         while (M_REQ && n < 40) begin
            n++;
            tick();
         end
         chk("t6_busy_cycles", 32'(n), 16);
         chk("t6_err", 32'(ERR), 1);
         chk("t6_ivalid", 32'(I_VALID), 1);
         chk("t6_irdata", I_RDATA, 32'h0000_0013);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
